// File: rtl/crc16_pkg.sv
// -----------------------------------------------------------------------------
// crc16_pkg
// Shared definitions for the crc16 frame serializer:
//   - CRC_W_DEF : default CRC / augmentation width
//   - ST_*      : FSM state encodings (plain constants, legacy-compatible)
//   - frame_len : cycles from an accepted frame to the next in_ready
// -----------------------------------------------------------------------------
package crc16_pkg;

    localparam int CRC_W_DEF = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // accept + clear + payload/augmentation bits + engine latency + done
    function automatic int frame_len(input int data_w, input int crc_w, input int crc_lat);
        return 1 + 1 + data_w + crc_w + crc_lat + 1;
    endfunction

endpackage

// File: rtl/crc16_ser_shift.sv
// -----------------------------------------------------------------------------
// crc16_ser_shift
// Parallel-load PISO holding {payload, CRC_W zeros} plus a bit down-counter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture din (with zero augmentation) and reload the counter
//   shift      : shift left one bit and count one emitted bit
//   din        : DATA_W payload
//   msb        : current MSB, the next bit to emit
//   last       : all DATA_W+CRC_W bits have been emitted (counter at zero)
// -----------------------------------------------------------------------------
module crc16_ser_shift
    import crc16_pkg::*;
#(
    parameter int DATA_W = 34,
    parameter int CRC_W  = CRC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb,
    output logic              last
);

    localparam int LEN   = DATA_W + CRC_W;
    localparam int CNT_W = $clog2(LEN + 1);

    logic [LEN-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = {din, {CRC_W{1'b0}}};
            cnt_d   = CNT_W'(LEN);
        end else if (shift) begin
            shreg_d = {shreg_q[LEN-2:0], 1'b0};
            // Saturate at zero; the counter is only ever reloaded by load.
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign msb  = shreg_q[LEN-1];
    assign last = (cnt_q == '0);

endmodule

// File: rtl/crc16_frame_serializer.sv
// -----------------------------------------------------------------------------
// crc16_frame_serializer
// Feeds a serial crc16 engine: accepts one DATA_W word, clears the engine,
// streams the word MSB-first followed by CRC_W zero bits, waits CRC_LAT
// cycles for the engine, then captures its CRC with a one-cycle strobe.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   in_valid/ready : frame handshake; in_ready only high in IDLE
//   in_data        : payload, bit DATA_W-1 sent first
//   ser_clr        : one-cycle engine clear pulse
//   ser_bit/valid  : serial bit stream to the engine (bit forced 0 when idle)
//   crc_in         : engine crc_out
//   crc_result     : CRC captured at the end of the last complete frame
//   crc_out_valid  : one-cycle strobe when crc_result updates
//   busy           : high in every state except IDLE
// All outputs are registered, computed from the next state.
// -----------------------------------------------------------------------------
module crc16_frame_serializer
    import crc16_pkg::*;
#(
    parameter int DATA_W  = 34,
    parameter int CRC_W   = CRC_W_DEF,
    parameter int CRC_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_clr,
    output logic              ser_bit,
    output logic              ser_valid,
    input  logic [CRC_W-1:0]  crc_in,
    output logic [CRC_W-1:0]  crc_result,
    output logic              crc_out_valid,
    output logic              busy
);

    localparam int WAIT_W = (CRC_LAT > 1) ? $clog2(CRC_LAT) : 1;

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              in_ready_q, in_ready_d;
    logic              ser_clr_q, ser_clr_d;
    logic              ser_bit_q, ser_bit_d;
    logic              ser_valid_q, ser_valid_d;
    logic [CRC_W-1:0]  crc_result_q, crc_result_d;
    logic              crc_out_valid_q, crc_out_valid_d;
    logic              busy_q, busy_d;

    logic accept;
    logic shift_en;
    logic sh_msb;
    logic sh_last;

    // in_ready_q is only set while idle, so it also gates acceptance and
    // keeps in_data unsampled for the whole frame.
    assign accept = in_valid && in_ready_q;

    // Shifting starts on the CLEAR->SHIFT edge so the first bit is on
    // ser_bit during the first SHIFT cycle; it stops once all bits are out.
    assign shift_en = (state_q == ST_CLEAR) || ((state_q == ST_SHIFT) && !sh_last);

    crc16_ser_shift #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (shift_en),
        .din   (in_data),
        .msb   (sh_msb),
        .last  (sh_last)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (sh_last) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_W'(CRC_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) state_d = ST_DONE;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_d      = (state_d == ST_IDLE);
        ser_clr_d       = (state_d == ST_CLEAR);
        ser_valid_d     = shift_en;
        ser_bit_d       = shift_en && sh_msb;
        busy_d          = (state_d != ST_IDLE);
        crc_out_valid_d = (state_d == ST_DONE);
        crc_result_d    = (state_d == ST_DONE) ? crc_in : crc_result_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            wait_q          <= '0;
            in_ready_q      <= 1'b0;
            ser_clr_q       <= 1'b0;
            ser_bit_q       <= 1'b0;
            ser_valid_q     <= 1'b0;
            crc_result_q    <= '0;
            crc_out_valid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            in_ready_q      <= in_ready_d;
            ser_clr_q       <= ser_clr_d;
            ser_bit_q       <= ser_bit_d;
            ser_valid_q     <= ser_valid_d;
            crc_result_q    <= crc_result_d;
            crc_out_valid_q <= crc_out_valid_d;
            busy_q          <= busy_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign ser_clr       = ser_clr_q;
    assign ser_bit       = ser_bit_q;
    assign ser_valid     = ser_valid_q;
    assign crc_result    = crc_result_q;
    assign crc_out_valid = crc_out_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_crc16_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_crc16_frame_serializer
// Two serializer instances (CRC_LAT=1 and CRC_LAT=3), each driving a
// behavioural serial crc16 engine (poly 0x1021). Expected CRCs come from a
// polynomial long-division model; a scoreboard queue holds one entry per
// accepted frame and is checked on each crc_out_valid strobe.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_crc16_frame_serializer;

    localparam logic [15:0] POLY = 16'h1021;

    typedef struct {
        logic [33:0] data;
        logic [15:0] crc;
    } vec_t;

    typedef struct {
        logic [33:0] data;
        logic [15:0] crc;
        int          e0;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_valid3 = 1'b0;
    logic [33:0] in_data = '0, in_data3 = '0;

    logic        in_ready, ser_clr, ser_bit, ser_valid, crc_out_valid, busy;
    logic [15:0] crc_result;
    logic        in_ready3, ser_clr3, ser_bit3, ser_valid3, crc_out_valid3, busy3;
    logic [15:0] crc_result3;

    logic [15:0] eng1_q, eng3_q, eng3_d1, eng3_d2;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    sb_t         sb1[$];
    sb_t         sb3[$];
    logic [49:0] cap1 = '0;
    int          nbits1 = 0;
    bit          zero_bad1 = 0, clr_chk1 = 0, ready_bad = 0;
    bit          cont_mode = 0;
    int          n_cont_acc = 0, last_e0 = 0;

    always #5 clk = ~clk;

    crc16_frame_serializer #(.DATA_W(34), .CRC_W(16), .CRC_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ser_clr(ser_clr), .ser_bit(ser_bit),
        .ser_valid(ser_valid), .crc_in(eng1_q), .crc_result(crc_result),
        .crc_out_valid(crc_out_valid), .busy(busy)
    );

    crc16_frame_serializer #(.DATA_W(34), .CRC_W(16), .CRC_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .ser_clr(ser_clr3), .ser_bit(ser_bit3),
        .ser_valid(ser_valid3), .crc_in(eng3_d2), .crc_result(crc_result3),
        .crc_out_valid(crc_out_valid3), .busy(busy3)
    );

    // Serial engines: augmented shift-register CRC, cleared by ser_clr.
    always @(posedge clk or posedge reset) begin
        if (reset)          eng1_q <= '0;
        else if (ser_clr)   eng1_q <= '0;
        else if (ser_valid) eng1_q <= {eng1_q[14:0], ser_bit} ^ (eng1_q[15] ? POLY : 16'h0);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng3_q  <= '0;
            eng3_d1 <= '0;
            eng3_d2 <= '0;
        end else begin
            if (ser_clr3)        eng3_q <= '0;
            else if (ser_valid3) eng3_q <= {eng3_q[14:0], ser_bit3} ^ (eng3_q[15] ? POLY : 16'h0);
            eng3_d1 <= eng3_q;
            eng3_d2 <= eng3_d1;
        end
    end

    // Remainder of (data * x^16) mod P by long division.
    function automatic logic [15:0] model_crc(input logic [33:0] d);
        logic [49:0] r;
        r = {d, 16'h0};
        for (int i = 49; i >= 16; i--) begin
            if (r[i]) r[i -: 17] = r[i -: 17] ^ {1'b1, POLY};
        end
        return r[15:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Accept detection on the active edge (pre-edge values).
    always @(posedge clk) begin : mon_accept
        sb_t e;
        cyc++;
        if (!reset && in_valid && in_ready) begin
            e.data = in_data;
            e.crc  = model_crc(in_data);
            e.e0   = cyc;
            sb1.push_back(e);
            clr_chk1  = 1;
            cap1      = '0;
            nbits1    = 0;
            zero_bad1 = 0;
            if (cont_mode) begin
                if (n_cont_acc > 0) check("accept_period", cyc - last_e0, 54);
                n_cont_acc++;
            end
            last_e0 = cyc;
        end
        if (!reset && in_valid3 && in_ready3) begin
            e.data = in_data3;
            e.crc  = model_crc(in_data3);
            e.e0   = cyc;
            sb3.push_back(e);
        end
    end

    // Output checks on the falling edge.
    always @(negedge clk) begin : mon_check
        sb_t e;
        if (reset) begin
            sb1.delete();
            sb3.delete();
            clr_chk1  = 0;
            nbits1    = 0;
            cap1      = '0;
            zero_bad1 = 0;
        end else begin
            if (clr_chk1) begin
                check("ser_clr_pulse", {ser_clr, ser_valid}, 2'b10);
                clr_chk1 = 0;
            end
            if (ser_valid) begin
                cap1 = {cap1[48:0], ser_bit};
                nbits1++;
            end else if (ser_bit) begin
                zero_bad1 = 1;
            end
            if (busy && in_ready) ready_bad = 1;
            if (crc_out_valid) begin
                check("sb_depth", sb1.size(), 1);
                if (sb1.size() > 0) begin
                    e = sb1.pop_front();
                    check("crc_result", crc_result, e.crc);
                    check("strobe_latency", cyc + 1 - e.e0, 53);
                    check("ser_stream", cap1, {e.data, 16'h0});
                    check("ser_bit_count", nbits1, 50);
                    check("ser_bit_zero_when_invalid", zero_bad1, 0);
                end
            end
            if (crc_out_valid3) begin
                check("sb3_depth", sb3.size(), 1);
                if (sb3.size() > 0) begin
                    e = sb3.pop_front();
                    check("lat3_crc_result", crc_result3, e.crc);
                    check("lat3_strobe_latency", cyc + 1 - e.e0, 55);
                end
            end
        end
    end

    task automatic send(input bit sel, input logic [33:0] d);
        int t = 0;
        while (!(sel ? in_ready3 : in_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!(sel ? in_ready3 : in_ready)) check("in_ready_timeout", sel ? in_ready3 : in_ready, 1);
        #1;
        if (sel) begin in_valid3 = 1'b1; in_data3 = d; end
        else     begin in_valid  = 1'b1; in_data  = d; end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
    endtask

    task automatic wait_strobe(input bit sel, input int lim, output bit seen, output bit held);
        logic [15:0] p;
        p    = sel ? crc_result3 : crc_result;
        held = 1;
        seen = 0;
        for (int t = 0; t < lim && !seen; t++) begin
            @(negedge clk);
            if (sel ? crc_out_valid3 : crc_out_valid) seen = 1;
            else if ((sel ? crc_result3 : crc_result) !== p) held = 0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t        tbl[5];
        bit          seen, held;
        int          t;
        logic [63:0] rnd;
        logic [33:0] d;

        tbl[0] = '{34'h2AAAAAAAA, model_crc(34'h2AAAAAAAA)};
        tbl[1] = '{34'h000000000, 16'h0000};
        tbl[2] = '{34'h000000001, 16'h1021};
        tbl[3] = '{34'h3FFFFFFFF, model_crc(34'h3FFFFFFFF)};
        tbl[4] = '{34'h2AAAAAAAA, model_crc(34'h2AAAAAAAA)};

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ctrl_outputs", {ser_clr, ser_valid, ser_bit, crc_out_valid}, 0);
        check("rst_crc_result", crc_result, 0);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        check("busy_idle", busy, 0);

        // Table-driven frames, sent back to back
        for (int i = 0; i < 5; i++) begin
            send(0, tbl[i].data);
            check("busy_in_frame", busy, 1);
            wait_strobe(0, 100, seen, held);
            check("strobe_seen", seen, 1);
            check("crc_hold_until_strobe", held, 1);
            check("tbl_crc", crc_result, tbl[i].crc);
            @(negedge clk);
            check("strobe_one_cycle", crc_out_valid, 0);
            check("ready_after_frame", in_ready, 1);
        end

        // in_valid held high; in_data scrambled mid-frame
        cont_mode  = 1;
        n_cont_acc = 0;
        in_data    = 34'h155555555;
        in_valid   = 1'b1;
        for (int f = 0; f < 3; f++) begin
            seen = 0;
            for (int k = 0; k < 120 && !seen; k++) begin
                @(negedge clk);
                if (crc_out_valid) begin
                    seen = 1;
                    if (f == 2) in_valid = 1'b0;
                end else if (!in_ready && k == 15) begin
                    rnd     = {$urandom(), $urandom()};
                    in_data = rnd[33:0];
                end
            end
            check("cont_strobe", seen, 1);
        end
        in_valid  = 1'b0;
        cont_mode = 0;
        check("cont_accepts", n_cont_acc, 3);

        // Reset in SHIFT cycle 20
        send(0, 34'h0F0F0F0F0);
        t = 0;
        while (nbits1 < 20 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reached_shift_cycle_20", nbits1, 20);
        #1 reset = 1'b1;
        #1;
        check("midrst_ser_valid", ser_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ser_bit", ser_bit, 0);
        check("midrst_crc_result", crc_result, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_strobe(0, 70, seen, held);
        check("no_strobe_after_reset", seen, 0);
        send(0, 34'h123456789);
        wait_strobe(0, 100, seen, held);
        check("post_reset_strobe", seen, 1);
        check("post_reset_crc", crc_result, model_crc(34'h123456789));

        // CRC_LAT=3 instance
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 34'h3FFFFFFFF : 34'h2AAAAAAAA;
            send(1, d);
            wait_strobe(1, 100, seen, held);
            check("lat3_strobe_seen", seen, 1);
            check("lat3_crc_hold", held, 1);
            check("lat3_crc", crc_result3, model_crc(d));
        end

        @(negedge clk);
        check("in_ready_low_while_busy", ready_bad, 0);
        check("sb_drained", sb1.size() + sb3.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
